// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage with 1-cycle memory, credit-gated issue
//            and a {pc, instr} FIFO toward decode.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     _reset,
  output logic [31:0]              pointer,
  output logic                     mem_req,
  input  logic [31:0]              instr_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int             c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_depth = DEPTH[c_aw:0];

  logic              r_running;
  logic              r_inflight;
  logic [31:0]       r_pointer;
  logic [31:0]       r_req_pc;
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic [31:0]       r_fifo_pc    [DEPTH];
  logic [31:0]       r_fifo_instr [DEPTH];

  logic              w_credit_ok;
  logic              w_push;
  logic              w_pop;

  // Credit counts the outstanding response too, so a push can never overflow.
  assign w_credit_ok = (r_count + {{c_aw{1'b0}}, r_inflight}) < c_depth;
  assign mem_req     = r_running & ~halt & ~redirect_valid & w_credit_ok;
  assign w_push      = r_inflight & ~redirect_valid;
  assign out_valid   = (r_count != '0) & ~redirect_valid;
  assign w_pop       = out_valid & out_ready;

  assign pointer     = r_pointer;
  assign fifo_count  = r_count;
  assign out_pc      = r_fifo_pc[r_rd_ptr];
  assign out_instr   = r_fifo_instr[r_rd_ptr];

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_running  <= 1'b0;
      r_inflight <= 1'b0;
      r_pointer  <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_running  <= 1'b1;
      r_inflight <= mem_req;
      if (mem_req) begin
        r_req_pc <= r_pointer;
      end
      if (redirect_valid) begin
        r_pointer <= redirect_pc;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
      end else begin
        if (mem_req) begin
          r_pointer <= r_pointer + PC_STEP;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_req_pc;
      r_fifo_instr[r_wr_ptr] <= instr_in;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!_reset)
    w_push |-> (r_count < c_depth));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed and randomized self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        _reset;
  logic [31:0] pointer;
  logic        mem_req;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [2:0]  fifo_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  int          pops;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd1),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    ._reset         (_reset),
    .pointer        (pointer),
    .mem_req        (mem_req),
    .instr_in       (instr_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fifo_count     (fifo_count)
  );

  // Memory: mem[i] = A000_0000 + i, one-cycle read latency
  always @(posedge clk) begin
    if (mem_req) instr_in <= 32'hA000_0000 + pointer;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ptr"},  pointer, 32'h0);
    check_eq({tag, "_req"},  {31'b0, mem_req}, 32'd0);
    check_eq({tag, "_val"},  {31'b0, out_valid}, 32'd0);
    check_eq({tag, "_cnt"},  {29'b0, fifo_count}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    _reset = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0;
    repeat (2) step();
    check_reset_vals("rst");

    // Streaming from reset
    _reset = 1'b1;
    #1;
    check_eq("rel_noreq", {31'b0, mem_req}, 32'd0);
    step();
    check_eq("first_req", {31'b0, mem_req}, 32'd1);
    check_eq("first_ptr", pointer, 32'h0);
    step();
    check_eq("lat_noval", {31'b0, out_valid}, 32'd0);
    check_eq("lat_ptr", pointer, 32'h1);
    step();
    for (int k = 0; k < 6; k++) begin
      check_eq("str_val", {31'b0, out_valid}, 32'd1);
      check_eq("str_pc", out_pc, 32'(k));
      check_eq("str_instr", out_instr, 32'hA000_0000 + 32'(k));
      check_eq("str_ptr", pointer, 32'(k + 2));
      step();
    end

    // Mid-stream async reset, then backpressure fill
    _reset = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_vals("async1");
    step();
    _reset = 1'b1;
    step();
    repeat (6) step();
    check_eq("full_ptr", pointer, 32'h4);
    check_eq("full_cnt", {29'b0, fifo_count}, 32'd4);
    check_eq("full_noreq", {31'b0, mem_req}, 32'd0);
    check_eq("full_val", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_eq("drain_val", {31'b0, out_valid}, 32'd1);
      check_eq("drain_pc", out_pc, 32'(k));
      check_eq("drain_instr", out_instr, 32'hA000_0000 + 32'(k));
      step();
    end

    // Redirect with 3 entries buffered and one response inflight
    _reset = 1'b0;
    #1;
    step();
    _reset = 1'b1; out_ready = 1'b0;
    step();
    repeat (4) step();
    check_eq("pre_redir_cnt", {29'b0, fifo_count}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check_eq("redir_noval", {31'b0, out_valid}, 32'd0);
    check_eq("redir_noreq", {31'b0, mem_req}, 32'd0);
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("post_redir_cnt", {29'b0, fifo_count}, 32'd0);
    check_eq("post_redir_val", {31'b0, out_valid}, 32'd0);
    check_eq("post_redir_ptr", pointer, 32'h100);
    check_eq("post_redir_req", {31'b0, mem_req}, 32'd1);
    step();
    check_eq("redir_lat_noval", {31'b0, out_valid}, 32'd0);
    step();
    check_eq("redir_first_val", {31'b0, out_valid}, 32'd1);
    check_eq("redir_first_pc", out_pc, 32'h100);
    check_eq("redir_first_instr", out_instr, 32'hA000_0100);
    step();

    // Halt for 5 cycles while streaming
    exp_pc = 32'h101;
    for (int i = 0; i < 12; i++) begin
      halt = (i < 5);
      #1;
      if (halt) check_eq("halt_noreq", {31'b0, mem_req}, 32'd0);
      if (out_valid) begin
        check_eq("halt_pc", out_pc, exp_pc);
        check_eq("halt_instr", out_instr, 32'hA000_0000 + exp_pc);
        exp_pc = exp_pc + 32'd1;
      end
      step();
    end
    halt = 1'b0;
    check_eq("halt_progress", exp_pc, 32'h108);

    // Redirect to the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("wrap_ptr0", pointer, 32'hFFFF_FFFF);
    check_eq("wrap_req", {31'b0, mem_req}, 32'd1);
    step();
    check_eq("wrap_ptr1", pointer, 32'h0);
    step();
    check_eq("wrap_val", {31'b0, out_valid}, 32'd1);
    check_eq("wrap_pc0", out_pc, 32'hFFFF_FFFF);
    check_eq("wrap_instr0", out_instr, 32'h9FFF_FFFF);
    step();
    check_eq("wrap_pc1", out_pc, 32'h0);
    check_eq("wrap_instr1", out_instr, 32'hA000_0000);

    // One-cycle reset mid-stream
    _reset = 1'b0;
    #1;
    check_reset_vals("async2");
    step();
    _reset = 1'b1;
    step();
    check_eq("restart_req", {31'b0, mem_req}, 32'd1);
    check_eq("restart_ptr", pointer, 32'h0);
    step();
    step();
    check_eq("restart_val", {31'b0, out_valid}, 32'd1);
    check_eq("restart_pc", out_pc, 32'h0);

    // Random backpressure, halts and redirects against a sequence model
    pops = 0;
    exp_pc = 32'h0;
    for (int i = 0; i < 10000; i++) begin
      redirect_valid = (i == 0) || ($urandom_range(0, 49) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : $urandom;
      halt           = ($urandom_range(0, 19) == 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      #1;
      check_eq("rand_cnt_le4", {31'b0, fifo_count <= 3'd4}, 32'd1);
      if (redirect_valid) begin
        check_eq("rand_redir_noval", {31'b0, out_valid}, 32'd0);
        exp_pc = redirect_pc;
      end else if (out_valid && out_ready) begin
        check_eq("rand_pc", out_pc, exp_pc);
        check_eq("rand_instr", out_instr, 32'hA000_0000 + out_pc);
        exp_pc = exp_pc + 32'd1;
        pops++;
      end
      step();
    end
    redirect_valid = 1'b0; halt = 1'b0;
    check_eq("rand_progress", {31'b0, pops > 2000}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage in front of the core.
- Drives the instruction-memory address (`pointer`) and captures the returned word (`instr_in`). Memory read latency is fixed at 1 cycle.
- Buffers fetched {pc, instr} pairs in a small FIFO. Hands them to decode over a valid/ready handshake.
- Supports pipeline redirects (branch/jump) and a halt request from the core.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- PC_STEP, 1, pointer increment per fetched word (word-addressed memory).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- _reset  input  1  asynchronous, active-low reset.
- pointer  output  32  instruction-memory address of the current request.
- mem_req  output  1  request strobe; memory returns mem[pointer] on instr_in in the next cycle.
- instr_in  input  32  instruction word returned one cycle after mem_req.
- out_valid  output  1  FIFO head valid toward decode.
- out_ready  input  1  decode accepts head.
- out_instr  output  32  head instruction.
- out_pc  output  32  address the head instruction was fetched from.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address.
- halt  input  1  level; while high no new requests are issued.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy (debug/verification).

Behaviour:
- Reset (async, while _reset=0):
  - pointer=RESET_PC, mem_req=0, out_valid=0, fifo_count=0.
  - running=0, inflight=0, FIFO pointers=0.
- running:
  - Set on the first posedge after _reset deasserts.
  - The first request is therefore issued 1 cycle after reset release.
- Issue condition (combinational):
  - mem_req = running & ~halt & ~redirect_valid & (fifo_count + inflight < DEPTH).
  - The credit check ignores a same-cycle pop (conservative).
- On posedge with mem_req=1:
  - pointer <= pointer + PC_STEP (32-bit wrap, 32'hFFFF_FFFF+1 = 0).
  - inflight <= 1; req_pc <= pointer.
- On posedge with mem_req=0: pointer holds; inflight <= 0.
- Response:
  - In the cycle after a request, instr_in is valid.
  - At the next posedge, {req_pc, instr_in} is pushed unless squashed.
  - Credit accounting guarantees no overflow. A push into a full FIFO is a design error; assert it in simulation.
- Output:
  - out_valid = (fifo_count != 0) & ~redirect_valid.
  - out_instr/out_pc show the head entry; values are don't-care when out_valid=0.
  - Pop occurs on posedge when out_valid & out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop with push into an empty FIFO is impossible (out_valid=0).
- Redirect (redirect_valid=1 in cycle t):
  - Priority over push, pop and issue.
  - At posedge ending t: FIFO cleared (count=0, pointers reset), any response arriving in t discarded, inflight <= 0, pointer <= redirect_pc.
  - No handshake completes in t.
  - In t+1, mem_req=1 at pointer=redirect_pc, provided halt=0.
  - Back-to-back redirects: the last one wins.
- Halt:
  - Stops issue only. An inflight response is still captured; FIFO contents stay poppable.
  - Deassertion resumes at the current pointer.
- Reset mid-operation: asynchronous clear of everything above; inflight response dropped.
- Throughput:
  - With out_ready held 1, steady state is one instruction per cycle.
  - Latency from request to out_valid is 2 cycles: request cycle t, response t+1, head valid t+2.

Test Plan:
- Reset release, RESET_PC=0, memory mem[i]=32'hA000_0000+i, out_ready=1:
  - Required: mem_req high 1 cycle after release; pointer 0,1,2,...
  - Required: out_valid first high 2 cycles after first req, with out_pc=0, out_instr=A000_0000, then one per cycle in order.
- out_ready=0 from start:
  - Required: exactly DEPTH=4 requests issued (pointer stops at 4), fifo_count saturates at 4, mem_req stays 0.
  - Then out_ready=1: pcs 0..3 drain in order, fetching resumes at 4.
- Redirect to 32'h100 while FIFO holds 3 entries and a response is inflight:
  - Required: next cycle fifo_count=0, out_valid=0, pointer=0x100, mem_req=1.
  - Required: the stale response never appears; next delivered out_pc=0x100, out_instr=A000_0100.
- Halt asserted for 5 cycles during streaming:
  - Required: no mem_req during halt; the inflight word is still delivered.
  - Required: after deassertion fetch continues at the next sequential address, with no gap or duplicate in the out_pc sequence.
- Redirect to 32'hFFFF_FFFF:
  - Required: pcs delivered FFFF_FFFF then 0000_0000 (wrap).
  - Also: assert _reset low mid-stream for one cycle, after which all outputs are at reset values immediately (async) and fetch restarts at RESET_PC.
- Random out_ready toggling with random redirects over 10k cycles, checked against a reference model:
  - Required: out_pc/out_instr always match mem[out_pc].
  - Required: pc sequence is sequential between redirects; FIFO never overflows; fifo_count ≤ 4.
